uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one UART transmitter between N_REQ byte producers, such as the LED-pattern source and status/debug sources.
- Grants one requester and latches its byte. Drives a start strobe to the transmitter, waits for completion, then acknowledges the requester.
- A watchdog recovers from a transmitter that never signals completion.
- Sits between the 25 MHz byte sources and the UART TX core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must be ≥ clog2(N_REQ).
- START_W, 1, tx_start high time in clocks (1..15).
- TIMEOUT, 8192, maximum clocks in WAIT before abort; must be > START_W. Default exceeds 1 byte at 9600 baud / 25 MHz only if tx_done is early; set per baud rate.

Ports:
- ext_clk_25m  in  1  system clock, 25 MHz.
- ext_rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request; held until ack.
- req_data  in  8*N_REQ  byte of requester i at bits [8i+7:8i].
- ack  out  N_REQ  one-cycle one-hot completion pulse to the granted requester.
- tx_data  out  8  byte presented to the UART TX; stable from START until the next grant.
- tx_start  out  1  start strobe to the UART TX.
- tx_busy  in  1  UART TX busy.
- tx_done  in  1  UART TX one-cycle completion pulse.
- grant_id  out  ID_W  index of the current or last granted requester.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky watchdog flag.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset values: ack = 0, tx_data = 8'h00, tx_start = 0, grant_id = 0, busy = 0, timeout_err = 0, rr pointer = 0, state = IDLE. Reset is asynchronous and may hit any state; tx_start drops immediately.
- FSM states: IDLE, START, WAIT, ACK.
- IDLE:
  - Grants only if any req bit is set and tx_busy = 0.
  - The winner is the first set req bit scanning from the pointer upward, with wrap from N_REQ-1 to 0.
  - On the granting edge: tx_data <= winner's byte, grant_id <= winner, tx_start <= 1, start counter <= 0, state <= START.
- START:
  - Counter increments each clock.
  - When count = START_W-1: tx_start <= 0, watchdog <= 0, state <= WAIT.
  - tx_start is therefore high for exactly START_W cycles, beginning one cycle after req is sampled.
- WAIT:
  - Watchdog increments each clock.
  - tx_done = 1: ack[grant_id] <= 1, state <= ACK.
  - Watchdog reaches TIMEOUT-1 without tx_done: timeout_err <= 1, ack[grant_id] <= 1, state <= ACK. The requester is released; the byte is considered lost.
  - tx_done and watchdog expiry in the same cycle: tx_done wins, no error.
- ACK:
  - ack <= 0 (pulse width is exactly 1).
  - pointer <= grant_id+1, with wrap modulo N_REQ.
  - state <= IDLE.
  - Minimum gap between consecutive grants is 1 IDLE cycle.
- Latching and ignored inputs:
  - req_data is sampled only on the granting edge; later changes are ignored.
  - A req bit dropped before ack does not abort the transfer; ack is still pulsed.
  - tx_done outside WAIT is ignored.
  - tx_busy is examined only in IDLE.
- Fairness: a requester holding req continuously is served within N_REQ grants.
- timeout_err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr = 1 clears it on the next edge.
- Widths: start counter is 4 bits; watchdog is clog2(TIMEOUT)+1 bits and does not wrap before compare.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding enum (IDLE = 0, START = 1, WAIT = 2, ACK = 3).
  - Byte width constant BYTE_W = 8.
  - Default TIMEOUT values per baud rate.
- One natural sub-module: rr_picker, a combinational round-robin priority selector. Inputs are req and pointer; outputs are a valid flag and the winner index.
- The FSM, counters and registers stay in uart_tx_arbiter.

Test Plan:
- Single request (N_REQ = 4): req = 4'b0100, byte 8'hA5, tx_busy = 0. Expect tx_start high 1 cycle later for START_W = 1 and tx_data = A5, grant_id = 2. Then tx_done 10 cycles later; expect ack = 4'b0100 the next cycle for exactly 1 cycle, and busy = 0 two cycles after tx_done.
- Round robin: req = 4'b1111 held with bytes 11/22/33/44 and tx_done returned 5 cycles after each start. Expect grant order 0, 1, 2, 3, 0. A second pass starting with pointer = 2 and req = 4'b1011 yields order 3, 0, 1.
- Busy hold-off: tx_busy = 1 with req = 4'b0001. Expect no tx_start for 20 cycles. Drop tx_busy; expect tx_start the next cycle.
- Timeout: TIMEOUT = 16 with no tx_done. Expect timeout_err = 1 and an ack pulse exactly 16 cycles after entering WAIT. Pulse err_clr; expect timeout_err = 0. Repeat with tx_done arriving on the expiry cycle; expect no error.
- Data stability and stray done:
  - Change req_data and drop req during WAIT; expect tx_data unchanged and ack still issued.
  - tx_done in IDLE produces no ack.
- Reset mid-transfer: assert ext_rst_n = 0 during START with tx_start = 1. Expect tx_start = 0, busy = 0 and grant_id = 0 without waiting for a clock edge. After release the pointer restarts at 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // One 10-bit frame at 25 MHz, rounded up with roughly 25% margin.
  localparam int TIMEOUT_9600    = 32768;
  localparam int TIMEOUT_19200   = 16384;
  localparam int TIMEOUT_57600   = 6144;
  localparam int TIMEOUT_115200  = 3072;
  localparam int TIMEOUT_DEFAULT = 8192;

  function automatic int timeout_for_baud(input int baud);
    case (baud)
      9600:    return TIMEOUT_9600;
      19200:   return TIMEOUT_19200;
      57600:   return TIMEOUT_57600;
      115200:  return TIMEOUT_115200;
      default: return TIMEOUT_DEFAULT;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  // Handshakes: a requester raises req[i] with its byte on req_data and holds
  // it until a single-cycle ack[i]; the arbiter raises tx_start for START_W
  // cycles and then waits for a single-cycle tx_done (or the watchdog).
  logic [N_REQ-1:0]        req;
  logic [BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]        ack;
  logic [BYTE_W-1:0]       tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    tx_done;
  logic [ID_W-1:0]         grant_id;
  logic                    busy;
  logic                    timeout_err;
  logic                    err_clr;

  modport master (
    input  req, req_data, tx_busy, tx_done, err_clr,
    output ack, tx_data, tx_start, grant_id, busy, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy, tx_done, err_clr,
    input  ack, tx_data, tx_start, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner = '0;
    sum    = '0;
    idx    = '0;
    // Scan from the farthest offset down so the nearest set bit is written last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (ID_W + 1)'(k);
      if (sum >= (ID_W + 1)'(N_REQ)) begin
        sum = sum - (ID_W + 1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        winner = idx;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with a watchdog that releases the requester if the transmitter never completes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int START_W = 1,
  parameter int TIMEOUT = 8192
) (
  input  logic               ext_clk_25m,
  input  logic               ext_rst_n,
  uart_tx_arbiter_if.master  bus,
  output arb_state_t         state_dbg
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  arb_state_t        state_q, state_n;
  logic [3:0]        start_cnt_q, start_cnt_n;
  logic [WD_W-1:0]   wdog_q, wdog_n;
  logic [ID_W-1:0]   ptr_q, ptr_n;
  logic [BYTE_W-1:0] tx_data_q, tx_data_n;
  logic              tx_start_q, tx_start_n;
  logic [ID_W-1:0]   grant_id_q, grant_id_n;
  logic [N_REQ-1:0]  ack_q, ack_n;
  logic              timeout_err_q, timeout_err_n;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [BYTE_W-1:0] req_bytes [N_REQ];
  logic [N_REQ-1:0]  grant_onehot;
  logic [ID_W-1:0]   next_ptr;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign grant_onehot = N_REQ'(1) << grant_id_q;
  assign next_ptr     = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

  always_ff @(posedge ext_clk_25m or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_q       <= IDLE;
      start_cnt_q   <= '0;
      wdog_q        <= '0;
      ptr_q         <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      grant_id_q    <= '0;
      ack_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      start_cnt_q   <= start_cnt_n;
      wdog_q        <= wdog_n;
      ptr_q         <= ptr_n;
      tx_data_q     <= tx_data_n;
      tx_start_q    <= tx_start_n;
      grant_id_q    <= grant_id_n;
      ack_q         <= ack_n;
      timeout_err_q <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    start_cnt_n   = start_cnt_q;
    wdog_n        = wdog_q;
    ptr_n         = ptr_q;
    tx_data_n     = tx_data_q;
    tx_start_n    = tx_start_q;
    grant_id_n    = grant_id_q;
    ack_n         = '0;
    timeout_err_n = timeout_err_q;

    // A watchdog expiry below overrides this clear in the same cycle.
    if (bus.err_clr) begin
      timeout_err_n = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_valid && !bus.tx_busy) begin
          tx_data_n   = req_bytes[pick_id];
          grant_id_n  = pick_id;
          tx_start_n  = 1'b1;
          start_cnt_n = '0;
          state_n     = START;
        end
      end
      START: begin
        start_cnt_n = start_cnt_q + 4'd1;
        if (start_cnt_q == 4'(START_W - 1)) begin
          tx_start_n = 1'b0;
          wdog_n     = '0;
          state_n    = WAIT;
        end
      end
      WAIT: begin
        wdog_n = wdog_q + WD_W'(1);
        if (bus.tx_done) begin
          ack_n   = grant_onehot;
          state_n = ACK;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          // Byte is abandoned; release the requester so the bus keeps moving.
          timeout_err_n = 1'b1;
          ack_n         = grant_onehot;
          state_n       = ACK;
        end
      end
      ACK: begin
        ptr_n   = next_ptr;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ack         = ack_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter against a queue-level arbitration model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int START_W = 1;
  localparam int TIMEOUT = 16;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();
  arb_state_t state_dbg;

  uart_tx_arbiter #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .START_W (START_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ext_clk_25m (clk),
    .ext_rst_n   (rst_n),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard queues: grants {id, byte} and acks {err, onehot}
  logic [ID_W+7:0] exp_q[$];
  logic [N_REQ:0]  exp_ack_q[$];

  // reference model state
  int         m_ptr = 0;
  bit         m_err = 1'b0;
  logic [7:0] bytes [N_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_REQ; i++) bus.req_data[i*8 +: 8] = bytes[i];
  endtask

  task automatic rand_data();
    for (int i = 0; i < N_REQ; i++) bytes[i] = 8'($urandom_range(0, 255));
    drive_data();
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("err_clr", bus.timeout_err, 0);
    m_err = 1'b0;
  endtask

  // One arbitrated transfer. done_dly = 0 means the transmitter never completes.
  task automatic do_xfer(input logic [N_REQ-1:0] mask, input int done_dly, input int busy_cyc,
                         input bit mutate, output int got_id);
    int               win;
    int               cyc;
    int               wait_ticks;
    bit               seen;
    bit               any;
    bit               tmo;
    logic [7:0]       exp_byte;
    logic [N_REQ-1:0] oh;
    got_id   = -1;
    win      = model_pick(mask, m_ptr);
    tmo      = (done_dly == 0);
    exp_byte = bytes[win];
    oh       = '0;
    oh[win]  = 1'b1;
    exp_q.push_back({ID_W'(win), exp_byte});
    exp_ack_q.push_back({m_err | tmo, oh});
    drive_data();
    bus.tx_busy = (busy_cyc > 0);
    bus.req     = mask;
    if (busy_cyc > 0) begin
      any = 1'b0;
      repeat (busy_cyc) begin
        tick();
        if (bus.tx_start) any = 1'b1;
      end
      check("busy_holdoff", 32'(any), 0);
      bus.tx_busy = 1'b0;
      tick();
      seen = bus.tx_start;
      check("start_after_busy", 32'(seen), 1);
    end else begin
      seen = 1'b0;
      cyc  = 0;
      while (cyc < 40 && !seen) begin
        tick();
        cyc++;
        seen = bus.tx_start;
      end
      check("start_latency", cyc, 1);
    end
    if (!seen) begin
      bus.req = '0;
      return;
    end
    got_id = int'(bus.grant_id);
    wait_ticks = tmo ? (START_W + TIMEOUT - 1) : done_dly;
    for (int k = 0; k < wait_ticks; k++) begin
      tick();
      if (mutate && k == 0) begin
        rand_data();
        bus.req = '0;
      end
    end
    if (!tmo) bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("ack_timing", bus.ack, 32'(oh));
    check("tx_data_hold", bus.tx_data, exp_byte);
    m_err = m_err | tmo;
    bus.req = '0;
    m_ptr = (win + 1) % N_REQ;
    tick();
    check("ack_pulse_end", bus.ack, 0);
    check("idle_after_ack", bus.busy, 0);
  endtask

  // monitor: pops the scoreboard whenever the DUT starts a byte or acks
  bit               prev_start = 1'b0;
  int               start_len  = 0;
  logic [N_REQ-1:0] prev_ack   = '0;
  logic [ID_W+7:0]  mon_e;
  logic [N_REQ:0]   mon_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      start_len  = 0;
      prev_ack   = '0;
    end else begin
      if (bus.tx_start) begin
        if (!prev_start) begin
          if (exp_q.size() == 0) begin
            check("start_unexpected", bus.tx_start, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("sb_tx_data", bus.tx_data, mon_e[7:0]);
            check("sb_grant_id", bus.grant_id, mon_e[ID_W+7:8]);
          end
          start_len = 1;
        end else begin
          start_len++;
        end
      end else if (prev_start) begin
        check("start_width", start_len, START_W);
      end
      if (bus.ack != '0) begin
        if (prev_ack != '0) begin
          check("ack_width", prev_ack, 0);
        end else if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", bus.ack, 0);
        end else begin
          mon_a = exp_ack_q.pop_front();
          check("sb_ack", bus.ack, mon_a[N_REQ-1:0]);
          check("sb_timeout_err", bus.timeout_err, mon_a[N_REQ]);
        end
      end
      prev_start = bus.tx_start;
      prev_ack   = bus.ack;
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "bench watchdog expired");
  end

  int         id;
  int         rr_order [5] = '{0, 1, 2, 3, 0};
  int         rr_order2[3] = '{3, 0, 1};
  logic [7:0] rr_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    bus.err_clr  = 1'b0;
    for (int i = 0; i < N_REQ; i++) bytes[i] = 8'h00;

    #5;
    check("rst_ack", bus.ack, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // round robin with all requesters held
    for (int i = 0; i < N_REQ; i++) bytes[i] = rr_bytes[i];
    for (int n = 0; n < 5; n++) begin
      do_xfer(4'b1111, 5, 0, 1'b0, id);
      check("rr_order", id, rr_order[n]);
    end
    do_xfer(4'b0010, 5, 0, 1'b0, id);
    check("rr_ptr_setup", id, 1);
    for (int n = 0; n < 3; n++) begin
      do_xfer(4'b1011, 5, 0, 1'b0, id);
      check("rr_order2", id, rr_order2[n]);
    end

    // single request
    bytes[2] = 8'hA5;
    do_xfer(4'b0100, 10, 0, 1'b0, id);
    check("single_grant", id, 2);

    // busy hold-off
    do_xfer(4'b0001, 5, 20, 1'b0, id);
    check("busy_grant", id, 0);

    // stray done in IDLE
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("stray_done_ack", bus.ack, 0);
    tick();
    check("stray_done_busy", bus.busy, 0);

    // data change and req drop during WAIT
    rand_data();
    do_xfer(4'b0100, 6, 0, 1'b1, id);
    check("mutate_grant", id, 2);

    // watchdog expiry, clear, expiry with clear held, done on expiry cycle
    do_xfer(4'b0001, 0, 0, 1'b0, id);
    check("timeout_set", bus.timeout_err, 1);
    pulse_clr();
    bus.err_clr = 1'b1;
    do_xfer(4'b0010, 0, 0, 1'b0, id);
    check("clr_after_hold", bus.timeout_err, 0);
    bus.err_clr = 1'b0;
    m_err = 1'b0;
    do_xfer(4'b0001, START_W + TIMEOUT - 1, 0, 1'b0, id);
    check("done_on_expiry", bus.timeout_err, 0);

    // reset during START
    do_xfer(4'b0010, 3, 0, 1'b0, id);
    rand_data();
    exp_q.push_back({ID_W'(2), bytes[2]});
    bus.req = 4'b0100;
    tick();
    check("rst_pre_start", bus.tx_start, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_start", bus.tx_start, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_grant_id", bus.grant_id, 0);
    bus.req = '0;
    m_ptr   = 0;
    m_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_xfer(4'b1111, 4, 0, 1'b0, id);
    check("ptr_after_rst", id, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      rand_data();
      if (m_err && $urandom_range(0, 1) == 1) pulse_clr();
      repeat ($urandom_range(0, 2)) tick();
      do_xfer(N_REQ'($urandom_range(1, 15)),
              ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(START_W, START_W + TIMEOUT - 1),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
              1'($urandom_range(0, 1)), id);
    end

    repeat (5) tick();
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_ack_q_empty", exp_ack_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
